gcd_ctrl: RTL and testbench

- Moore FSM that sequences the 16-bit subtract-based GCD datapath (registers A/B, operand muxes, subtractor, comparator).
- Accepts a start request and steers two operands from the shared data_in bus into A then B.
- Drives repeated-subtraction iterations off the comparator flags until A==B.
- Reports done, or an error when an iteration budget is exhausted (covers zero-operand cases that would otherwise never terminate).

---
 rtl/gcd_ctrl.sv | 106 ++++++++++
 tb/tb_gcd_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/gcd_ctrl.sv
// Control FSM for a subtract-based 16-bit GCD datapath.
// It loads A and B from data_in, then subtracts the smaller operand from the larger until A==B or the iteration budget runs out.
module gcd_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             lt,
  input  logic             gt,
  input  logic             eq,
  output logic             lda,
  output logic             ldb,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_CMP, S_SUB_A, S_SUB_B, S_DONE, S_ERR
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The budget check comes before the gt/lt checks. This keeps the counter from passing MAX_ITER, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lda     = 1'b0;
    ldb     = 1'b0;
    sel1    = 1'b0;
    sel2    = 1'b0;
    sel_in  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end
      end
      S_LOAD_A: begin
        lda     = 1'b1;
        sel_in  = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        ldb     = 1'b1;
        sel_in  = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (eq)                  state_d = S_DONE;
        else if (cnt_q == MAX_CNT) state_d = S_ERR;
        else if (gt)             state_d = S_SUB_A;
        else if (lt)             state_d = S_SUB_B;
        else                     state_d = S_ERR;
      end
      S_SUB_A: begin
        lda     = 1'b1;
        sel2    = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_CMP;
      end
      S_SUB_B: begin
        ldb     = 1'b1;
        sel1    = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_CMP;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign iter_count = cnt_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl. A behavioural datapath produces the comparator flags.
// A GCD-trace model predicts the expected outputs for every cycle.
module tb_gcd_ctrl;
  localparam int CNT_W    = 16;
  localparam int MAX_ITER = 8;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic lt, gt, eq;
  logic lda, ldb, sel1, sel2, sel_in, busy, done, err;
  logic [CNT_W-1:0] iter_count;

  gcd_ctrl #(.CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lt(lt), .gt(gt), .eq(eq),
    .lda(lda), .ldb(ldb), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .busy(busy), .done(done), .err(err), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  // Datapath environment. When ovr is set, the flags are forced directly.
  logic [15:0] data_in = 16'h0, dp_a = 16'h0, dp_b = 16'h0, mux1, mux2;
  logic        ovr = 1'b0;
  logic [2:0]  ovr_f = 3'b000;
  assign mux1 = sel1 ? dp_b : dp_a;
  assign mux2 = sel2 ? dp_b : dp_a;
  assign {eq, gt, lt} = ovr ? ovr_f : {dp_a == dp_b, dp_a > dp_b, dp_a < dp_b};
  always @(posedge clk) begin
    if (lda) dp_a <= sel_in ? data_in : mux1 - mux2;
    if (ldb) dp_b <= sel_in ? data_in : mux1 - mux2;
  end

  // Output bits: {lda,ldb,sel1,sel2,sel_in,busy,done,err}
  localparam logic [7:0] V_IDLE = 8'b0000_0000, V_LDA = 8'b1000_1100,
                         V_LDB  = 8'b0100_1100, V_CMP = 8'b0000_0100,
                         V_SUBA = 8'b1001_0100, V_SUBB = 8'b0110_0100,
                         V_DONE = 8'b0000_0110, V_ERR = 8'b0000_0101;
  wire [7:0] outs = {lda, ldb, sel1, sel2, sel_in, busy, done, err};

  typedef struct { logic [7:0] o; logic [15:0] cnt; } exp_t;
  exp_t        q[$];
  logic [15:0] last_cnt = 16'h0;
  int          errors = 0, checks = 0;
  bit          cmp_en = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic void push(logic [7:0] o, logic [15:0] c);
    exp_t e;
    e.o = o;
    e.cnt = c;
    q.push_back(e);
  endfunction

  // Replay the GCD arithmetic and queue the expected outputs from t0 (the start cycle) to the terminal cycle.
  // Returns the index of the terminal cycle.
  function automatic int build(logic [15:0] a_in, logic [15:0] b_in);
    logic [15:0] a, b;
    logic [2:0]  f;
    int k, t;
    a = a_in; b = b_in; k = 0; t = 3;
    push(V_IDLE, last_cnt);
    push(V_LDA, 16'd0);
    push(V_LDB, 16'd0);
    forever begin
      f = ovr ? ovr_f : {a == b, a > b, a < b};
      push(V_CMP, 16'(k));
      if (f[2])               begin push(V_DONE, 16'(k)); break; end
      else if (k == MAX_ITER) begin push(V_ERR, 16'(k));  break; end
      else if (f[1])          begin push(V_SUBA, 16'(k)); a = a - b; end
      else if (f[0])          begin push(V_SUBB, 16'(k)); b = b - a; end
      else                    begin push(V_ERR, 16'(k));  break; end
      k++;
      t += 2;
    end
    last_cnt = 16'(k);
    return t + 1;
  endfunction

  always @(negedge clk) begin : cmp
    exp_t e;
    if (cmp_en) begin
      if (q.size() > 0) e = q.pop_front();
      else begin e.o = V_IDLE; e.cnt = last_cnt; end
      chk("outputs", {24'h0, outs}, {24'h0, e.o});
      chk("iter_count", {16'h0, iter_count}, {16'h0, e.cnt});
    end
  end

  // Call this task 1 time unit after a rising edge. It returns 1 time unit after the first idle edge that follows the run.
  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input int pulse_at, input int rst_at, output int tend);
    tend  = build(a, b);
    start = 1'b1;
    for (int i = 1; i < 200 && q.size() > 0; i++) begin
      @(posedge clk); #1;
      start   = (i == pulse_at);
      rst_n   = 1'b1;
      data_in = (i == 1) ? a : (i == 2) ? b : 16'hdead;
      if (i == rst_at) begin
        rst_n = 1'b0;
        q = q[0:0];
        push(V_IDLE, 16'd0);
        last_cnt = 16'd0;
      end
    end
    if (q.size() > 0) begin
      chk("run_timeout", 32'd1, 32'd0);
      q.delete();
    end
  endtask

  int t;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {24'h0, outs}, 32'd0);
    chk("reset_cnt", {16'h0, iter_count}, 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    run(16'd12, 16'd12, -1, -1, t);
    chk("t_12_12", t, 4);    chk("A_12_12", dp_a, 12); chk("cnt_12_12", iter_count, 0);
    run(16'd12, 16'd8, 5, -1, t);
    chk("t_12_8", t, 8);     chk("A_12_8", dp_a, 4);   chk("B_12_8", dp_b, 4);
    chk("cnt_12_8", iter_count, 2);
    run(16'd48, 16'd18, -1, -1, t);
    chk("t_48_18", t, 12);   chk("A_48_18", dp_a, 6);  chk("cnt_48_18", iter_count, 4);
    run(16'd0, 16'd5, -1, -1, t);
    chk("t_0_5", t, 20);     chk("cnt_0_5", iter_count, 8);
    run(16'd0, 16'd0, -1, -1, t);
    chk("t_0_0", t, 4);      chk("A_0_0", dp_a, 0);
    run(16'd48, 16'd18, -1, 4, t);
    chk("cnt_after_rst", iter_count, 0);
    run(16'd7, 16'd7, -1, -1, t);
    chk("t_7_7", t, 4);      chk("A_7_7", dp_a, 7);

    // Forced flags check the priority rules and the no-flag case.
    ovr = 1'b1;
    ovr_f = 3'b000; run(16'd3, 16'd3, -1, -1, t); chk("t_noflag", t, 4);
    ovr_f = 3'b110; run(16'd3, 16'd3, -1, -1, t); chk("t_eq_gt", t, 4);
    ovr_f = 3'b011; run(16'd9, 16'd3, -1, -1, t); chk("t_gt_lt", t, 20);
    chk("cnt_gt_lt", iter_count, 8);
    ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
